// File: rtl/servant_uart.sv
// Wishbone-attached transmit-only UART: byte FIFO feeding an 8N1 serializer
// with a runtime-programmable baud divisor.
module servant_uart #(
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned DIV_RESET = 139
) (
  input  logic        wb_clk,
  input  logic        wb_rst,
  input  logic        i_wb_adr,
  input  logic [31:0] i_wb_dat,
  input  logic        i_wb_we,
  input  logic        i_wb_stb,
  output logic [31:0] o_wb_rdt,
  output logic        o_wb_ack,
  output logic        o_uart_tx
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [7:0]    mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [CW-1:0] count;
  logic          ovf;
  logic [15:0]   div;
  logic [15:0]   baud_cnt;
  logic [7:0]    shift;
  logic [2:0]    bit_cnt;

  logic          access_c;
  logic          wr_data_c;
  logic          wr_div_c;
  logic          rd_stat_c;
  logic          full_c;
  logic          empty_c;
  logic          bit_end_c;
  logic          pop_c;
  logic          push_c;
  logic [15:0]   div_m1_c;
  logic [31:0]   rdt_c;
  logic          unused_dat;

  assign unused_dat = ^i_wb_dat[31:16];

  // Access decode, FIFO handshake and read-data mux
  always_comb begin
    access_c  = i_wb_stb & ~o_wb_ack;
    wr_data_c = access_c & i_wb_we & ~i_wb_adr;
    wr_div_c  = access_c & i_wb_we & i_wb_adr;
    rd_stat_c = access_c & ~i_wb_we & ~i_wb_adr;
    full_c    = (count == CW'(DEPTH));
    empty_c   = (count == '0);
    bit_end_c = (baud_cnt == '0);
    pop_c     = ~empty_c & ((state == IDLE) | ((state == STOP) & bit_end_c));
    push_c    = wr_data_c & (~full_c | pop_c);
    div_m1_c  = (div == '0) ? 16'd0 : div - 16'd1;
    rdt_c     = '0;
    if (i_wb_adr) begin
      rdt_c = {16'd0, div};
    end else begin
      rdt_c[0]    = full_c;
      rdt_c[1]    = empty_c;
      rdt_c[2]    = (state != IDLE);
      rdt_c[3]    = ovf;
      rdt_c[12:8] = 5'(count);
    end
  end

  // FIFO storage is not reset; only the pointers and count define its contents
  always_ff @(posedge wb_clk) begin
    if (push_c) mem[wr_ptr] <= i_wb_dat[7:0];
  end

  always_ff @(posedge wb_clk) begin
    if (wb_rst) begin
      o_wb_ack  <= 1'b0;
      o_wb_rdt  <= '0;
      o_uart_tx <= 1'b1;
      state     <= IDLE;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      ovf       <= 1'b0;
      div       <= 16'(DIV_RESET);
      baud_cnt  <= '0;
      shift     <= '0;
      bit_cnt   <= '0;
    end else begin
      o_wb_ack <= access_c;
      o_wb_rdt <= (access_c & ~i_wb_we) ? rdt_c : 32'd0;
      if (wr_div_c) div <= i_wb_dat[15:0];
      if (wr_data_c & ~push_c) ovf <= 1'b1;
      else if (rd_stat_c)      ovf <= 1'b0;
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      if (push_c & ~pop_c)      count <= count + CW'(1);
      else if (pop_c & ~push_c) count <= count - CW'(1);

      // Divisor is sampled only at bit boundaries, so a new value never splits a bit
      case (state)
        IDLE: begin
          if (pop_c) begin
            shift     <= mem[rd_ptr];
            bit_cnt   <= '0;
            baud_cnt  <= div_m1_c;
            o_uart_tx <= 1'b0;
            state     <= START;
          end
        end
        START: begin
          if (bit_end_c) begin
            o_uart_tx <= shift[0];
            shift     <= shift >> 1;
            baud_cnt  <= div_m1_c;
            state     <= DATA;
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end_c) begin
            baud_cnt <= div_m1_c;
            if (bit_cnt == 3'd7) begin
              o_uart_tx <= 1'b1;
              state     <= STOP;
            end else begin
              o_uart_tx <= shift[0];
              shift     <= shift >> 1;
              bit_cnt   <= bit_cnt + 3'd1;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_end_c) begin
            if (pop_c) begin
              shift     <= mem[rd_ptr];
              bit_cnt   <= '0;
              baud_cnt  <= div_m1_c;
              o_uart_tx <= 1'b0;
              state     <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt - 16'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_servant_uart.sv
// Scoreboard bench for servant_uart: bus responses and serial bytes are queued
// by the stimulus and checked by independent monitors.
module tb_servant_uart;

  logic        wb_clk = 1'b0;
  logic        wb_rst = 1'b1;
  logic        i_wb_adr = 1'b0;
  logic [31:0] i_wb_dat = '0;
  logic        i_wb_we = 1'b0;
  logic        i_wb_stb = 1'b0;
  logic [31:0] o_wb_rdt;
  logic        o_wb_ack;
  logic        o_uart_tx;

  always #5 wb_clk = ~wb_clk;

  servant_uart #(.DEPTH(4), .DIV_RESET(139)) dut (
    .wb_clk    (wb_clk),
    .wb_rst    (wb_rst),
    .i_wb_adr  (i_wb_adr),
    .i_wb_dat  (i_wb_dat),
    .i_wb_we   (i_wb_we),
    .i_wb_stb  (i_wb_stb),
    .o_wb_rdt  (o_wb_rdt),
    .o_wb_ack  (o_wb_ack),
    .o_uart_tx (o_uart_tx)
  );

  int unsigned n_pass = 0;
  int unsigned n_total = 0;
  int unsigned cyc = 0;
  int unsigned ack_seen = 0;
  int unsigned rdt_idle_errs = 0;
  int unsigned rx_div = 4;
  logic        mon_en = 1'b0;
  logic        rx_en = 1'b1;
  logic [31:0] exp_q[$];
  logic [7:0]  exp_rx[$];
  int unsigned start_ts[$];

  always @(posedge wb_clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Bus monitor: every acknowledge consumes one expected read-data word
  always @(negedge wb_clk) begin
    if (mon_en) begin
      if (o_wb_ack === 1'b1) begin
        ack_seen++;
        check("ack_expected", 32'(exp_q.size() != 0), 32'd1);
        if (exp_q.size() != 0) check("rdt", o_wb_rdt, exp_q.pop_front());
      end else if (o_wb_rdt !== 32'd0) begin
        rdt_idle_errs++;
      end
    end
  end

  // Serial monitor: mid-bit sampling of 8N1 frames at the bench's divisor
  initial begin : uart_rx
    int unsigned d;
    logic [7:0]  b;
    forever begin
      @(negedge wb_clk);
      if (rx_en && !wb_rst && o_uart_tx === 1'b0) begin
        d = rx_div;
        start_ts.push_back(cyc);
        repeat (d / 2) @(negedge wb_clk);
        check("rx_start_bit", 32'(o_uart_tx), 32'd0);
        for (int k = 0; k < 8; k++) begin
          repeat (d) @(negedge wb_clk);
          b[k] = o_uart_tx;
        end
        repeat (d) @(negedge wb_clk);
        check("rx_stop_bit", 32'(o_uart_tx), 32'd1);
        check("rx_byte_expected", 32'(exp_rx.size() != 0), 32'd1);
        if (exp_rx.size() != 0) check("rx_byte", 32'(b), 32'(exp_rx.pop_front()));
      end
    end
  end

  task automatic xfer(input logic adr, input logic we, input logic [31:0] dat,
                      input logic [31:0] exp_rdt);
    bit got;
    exp_q.push_back(exp_rdt);
    @(negedge wb_clk);
    i_wb_adr = adr;
    i_wb_we  = we;
    i_wb_dat = dat;
    i_wb_stb = 1'b1;
    got = 1'b0;
    for (int n = 0; n < 16 && !got; n++) begin
      @(posedge wb_clk);
      #1;
      got = (o_wb_ack === 1'b1);
    end
    i_wb_stb = 1'b0;
    i_wb_we  = 1'b0;
    check("ack_within_bound", 32'(got), 32'd1);
  endtask

  task automatic send(input logic [31:0] dat, input bit expect_out);
    if (expect_out) exp_rx.push_back(dat[7:0]);
    xfer(1'b0, 1'b1, dat, 32'd0);
  endtask

  function automatic logic exp_frame55(int i);
    logic [7:0] v;
    int slot;
    v = 8'h55;
    slot = i / 4;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return v[slot-1];
    return 1'b1;
  endfunction

  function automatic logic exp_frame0f(int i);
    logic [7:0] v;
    v = 8'h0F;
    if (i < 4)  return 1'b0;
    if (i < 8)  return v[0];
    if (i < 64) return v[(i - 8) / 8 + 1];
    return 1'b1;
  endfunction

  initial begin : stim
    int unsigned errs;
    int unsigned acks0;
    logic [5:0]  ack_pat;

    // Reset with an access pending: nothing may execute or acknowledge
    i_wb_stb = 1'b1; i_wb_we = 1'b1; i_wb_adr = 1'b1; i_wb_dat = 32'd5;
    repeat (3) @(negedge wb_clk);
    check("reset_tx", 32'(o_uart_tx), 32'd1);
    check("reset_ack", 32'(o_wb_ack), 32'd0);
    check("reset_rdt", o_wb_rdt, 32'd0);
    i_wb_stb = 1'b0; i_wb_we = 1'b0;
    @(negedge wb_clk);
    wb_rst = 1'b0;
    mon_en = 1'b1;
    xfer(1'b1, 1'b0, 32'd0, 32'd139);
    xfer(1'b0, 1'b0, 32'd0, 32'h0000_0002);
    xfer(1'b1, 1'b1, 32'hABCD_0004, 32'd0);
    xfer(1'b1, 1'b0, 32'd0, 32'd4);

    // Single 0x55 frame at DIV=4: latency and exact line waveform
    rx_div = 4;
    send(32'h0000_0055, 1'b1);
    @(negedge wb_clk);
    check("tx_high_cycle_e1", 32'(o_uart_tx), 32'd1);
    errs = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge wb_clk);
      if (o_uart_tx !== exp_frame55(i)) errs++;
    end
    check("frame55_waveform_errs", errs, 32'd0);
    repeat (2) @(negedge wb_clk);
    xfer(1'b0, 1'b0, 32'd0, 32'h0000_0002);

    // Five back-to-back bytes into a depth-4 FIFO: no gap, no overflow
    start_ts.delete();
    send(32'hDEAD_BE01, 1'b1);
    send(32'h0000_0080, 1'b1);
    send(32'h1234_56A5, 1'b1);
    send(32'h0000_003C, 1'b1);
    send(32'hFFFF_FFFF, 1'b1);
    xfer(1'b0, 1'b0, 32'd0, 32'h0000_0405);
    repeat (215) @(negedge wb_clk);
    check("b2b_frame_count", start_ts.size(), 32'd5);
    for (int i = 1; i < 5 && i < start_ts.size(); i++)
      check("b2b_start_spacing", start_ts[i] - start_ts[i-1], 32'd40);
    xfer(1'b0, 1'b0, 32'd0, 32'h0000_0002);

    // Overflow at DIV=100: sixth byte dropped, OVF sticky until read
    xfer(1'b1, 1'b1, 32'd100, 32'd0);
    rx_div = 100;
    send(32'h0000_0011, 1'b1);
    send(32'h0000_0022, 1'b1);
    send(32'h0000_0033, 1'b1);
    send(32'h0000_0044, 1'b1);
    send(32'h0000_0055, 1'b1);
    send(32'h0000_0066, 1'b0);
    xfer(1'b0, 1'b0, 32'd0, 32'h0000_040D);
    xfer(1'b0, 1'b0, 32'd0, 32'h0000_0405);
    repeat (5010) @(negedge wb_clk);
    xfer(1'b0, 1'b0, 32'd0, 32'h0000_0002);

    // Divisor change from 4 to 8 during data bit 0
    xfer(1'b1, 1'b1, 32'd4, 32'd0);
    rx_en = 1'b0;
    send(32'h0000_000F, 1'b0);
    errs = 0;
    fork
      begin
        @(negedge wb_clk);
        for (int i = 0; i < 72; i++) begin
          @(negedge wb_clk);
          if (o_uart_tx !== exp_frame0f(i)) errs++;
        end
      end
      begin
        repeat (6) @(negedge wb_clk);
        xfer(1'b1, 1'b1, 32'd8, 32'd0);
      end
    join
    check("div_change_waveform_errs", errs, 32'd0);
    repeat (3) @(negedge wb_clk);
    xfer(1'b1, 1'b0, 32'd0, 32'd8);
    xfer(1'b0, 1'b0, 32'd0, 32'h0000_0002);

    // Strobe held for six cycles: acknowledge alternates, three reads execute
    repeat (2) @(negedge wb_clk);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd8);
    exp_q.push_back(32'd8);
    acks0 = ack_seen;
    i_wb_adr = 1'b1; i_wb_we = 1'b0; i_wb_stb = 1'b1;
    ack_pat = '0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) @(negedge wb_clk);
      ack_pat[i] = o_wb_ack;
    end
    i_wb_stb = 1'b0;
    repeat (2) @(negedge wb_clk);
    check("held_stb_ack_pattern", 32'(ack_pat), 32'(6'b101010));
    check("held_stb_access_count", ack_seen - acks0, 32'd3);

    // Reset at data bit 3 with two bytes queued
    send(32'h0000_0000, 1'b0);
    send(32'h0000_0011, 1'b0);
    send(32'h0000_0022, 1'b0);
    repeat (31) @(negedge wb_clk);
    check("pre_reset_tx_bit3", 32'(o_uart_tx), 32'd0);
    wb_rst = 1'b1;
    @(negedge wb_clk);
    check("reset_midframe_tx", 32'(o_uart_tx), 32'd1);
    check("reset_midframe_ack", 32'(o_wb_ack), 32'd0);
    @(negedge wb_clk);
    wb_rst = 1'b0;
    xfer(1'b0, 1'b0, 32'd0, 32'h0000_0002);
    xfer(1'b1, 1'b0, 32'd0, 32'd139);
    errs = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge wb_clk);
      if (o_uart_tx !== 1'b1) errs++;
    end
    check("post_reset_line_idle_errs", errs, 32'd0);

    repeat (4) @(negedge wb_clk);
    check("rdt_zero_without_ack_errs", rdt_idle_errs, 32'd0);
    check("ack_queue_drained", exp_q.size(), 32'd0);
    check("rx_queue_drained", exp_rx.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
